// File: rtl/plate_locate_if.sv
// Binary mask video stream into the plate locator and the bounding-box result out of it.
interface plate_locate_if;
    logic       per_frame_vsync;
    logic       per_frame_href;
    logic       per_frame_clken;
    logic       per_frame_bit;
    logic [9:0] plate_boarder_up;
    logic [9:0] plate_boarder_down;
    logic [9:0] plate_boarder_left;
    logic [9:0] plate_boarder_right;
    logic       plate_exist_flag;
    logic       result_valid;
    logic       frame_overrun;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_frame_bit,
        input  plate_boarder_up, plate_boarder_down, plate_boarder_left, plate_boarder_right,
        input  plate_exist_flag, result_valid, frame_overrun
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_frame_bit,
        output plate_boarder_up, plate_boarder_down, plate_boarder_left, plate_boarder_right,
        output plate_exist_flag, result_valid, frame_overrun
    );
endinterface

// File: rtl/plate_locate.sv
// Plate bounding box from row/column projections of a 1-bit mask; results refresh once per
// frame in vertical blank. Column counts live in a RAM that is cleared while it is scanned.
module plate_locate #(
    parameter logic [9:0] IMG_HDISP  = 10'd640,
    parameter logic [9:0] IMG_VDISP  = 10'd480,
    parameter logic [9:0] ROW_THRESH = 10'd20,
    parameter logic [9:0] COL_THRESH = 10'd10,
    parameter logic [9:0] MIN_W      = 10'd40,
    parameter logic [9:0] MIN_H      = 10'd12
) (
    input  logic          clk,
    input  logic          rst,
    plate_locate_if.slave pif
);
    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_ACCUM = 3'd2,
        S_SCAN  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic        vsync_d_r, href_d_r;
    logic        vsync_rise_s, vsync_fall_s, href_fall_s, pix_en_s;
    logic [9:0]  cnt_r, x_r, y_r, row_cnt_r;
    logic        row_found_r, col_found_r;
    logic [9:0]  up_tmp_r, down_tmp_r, left_tmp_r, right_tmp_r;
    logic        pend_r, pend_bit_r;
    logic [9:0]  pend_addr_r;
    logic [9:0]  col_mem_r [0:IMG_HDISP-10'd1];
    logic        mem_we_s, mem_re_s;
    logic [9:0]  mem_waddr_s, mem_wdata_s, mem_raddr_s, mem_rdata_r;
    logic [10:0] width_s, height_s;
    logic        exist_s;

    assign vsync_rise_s = pif.per_frame_vsync & ~vsync_d_r;
    assign vsync_fall_s = ~pif.per_frame_vsync & vsync_d_r;
    assign href_fall_s  = ~pif.per_frame_href & href_d_r;
    assign pix_en_s     = (state_r == S_ACCUM) & pif.per_frame_vsync & pif.per_frame_href &
                          pif.per_frame_clken & (x_r < IMG_HDISP) & (y_r < IMG_VDISP);

    assign height_s = {1'b0, down_tmp_r} - {1'b0, up_tmp_r} + 11'd1;
    assign width_s  = {1'b0, right_tmp_r} - {1'b0, left_tmp_r} + 11'd1;
    assign exist_s  = row_found_r & col_found_r &
                      (height_s >= {1'b0, MIN_H}) & (width_s >= {1'b0, MIN_W});

    // RAM port arbitration: init clear, pixel read-modify-write, scan read-then-clear
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = 10'd0;
        mem_wdata_s = 10'd0;
        mem_re_s    = 1'b0;
        mem_raddr_s = 10'd0;
        if (state_r == S_INIT) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_r;
        end else if (pend_r) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = pend_addr_r;
            if (mem_rdata_r == 10'd1023) begin
                mem_wdata_s = mem_rdata_r;
            end else begin
                mem_wdata_s = mem_rdata_r + {9'd0, pend_bit_r};
            end
        end else if ((state_r == S_SCAN) && (cnt_r != 10'd0)) begin
            // the address read one cycle earlier is zeroed behind the scan
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_r - 10'd1;
        end else begin
            mem_we_s    = 1'b0;
        end
        if (pix_en_s) begin
            mem_re_s    = 1'b1;
            mem_raddr_s = x_r;
        end else if ((state_r == S_SCAN) && (cnt_r < IMG_HDISP)) begin
            mem_re_s    = 1'b1;
            mem_raddr_s = cnt_r;
        end else begin
            mem_re_s    = 1'b0;
        end
    end

    // Column-count RAM with one write port and a registered read port
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            col_mem_r[mem_waddr_s] <= mem_wdata_s;
        end
        if (mem_re_s) begin
            mem_rdata_r <= col_mem_r[mem_raddr_s];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_INIT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_INIT:  if (cnt_r == IMG_HDISP - 10'd1) state_s = S_IDLE;  else state_s = S_INIT;
            S_IDLE:  if (vsync_rise_s)               state_s = S_ACCUM; else state_s = S_IDLE;
            S_ACCUM: if (vsync_fall_s)               state_s = S_SCAN;  else state_s = S_ACCUM;
            S_SCAN:  if (cnt_r == IMG_HDISP)         state_s = S_DONE;  else state_s = S_SCAN;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_INIT;
        endcase
    end

    // Projection datapath and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d_r               <= 1'b0;
            href_d_r                <= 1'b0;
            cnt_r                   <= 10'd0;
            x_r                     <= 10'd0;
            y_r                     <= 10'd0;
            row_cnt_r               <= 10'd0;
            row_found_r             <= 1'b0;
            col_found_r             <= 1'b0;
            up_tmp_r                <= 10'd0;
            down_tmp_r              <= 10'd0;
            left_tmp_r              <= 10'd0;
            right_tmp_r             <= 10'd0;
            pend_r                  <= 1'b0;
            pend_bit_r              <= 1'b0;
            pend_addr_r             <= 10'd0;
            pif.plate_boarder_up    <= 10'd0;
            pif.plate_boarder_down  <= 10'd0;
            pif.plate_boarder_left  <= 10'd0;
            pif.plate_boarder_right <= 10'd0;
            pif.plate_exist_flag    <= 1'b0;
            pif.result_valid        <= 1'b0;
            pif.frame_overrun       <= 1'b0;
        end else begin
            vsync_d_r         <= pif.per_frame_vsync;
            href_d_r          <= pif.per_frame_href;
            pend_r            <= pix_en_s;
            pend_bit_r        <= pif.per_frame_bit;
            pend_addr_r       <= x_r;
            pif.result_valid  <= (state_r == S_DONE);
            pif.frame_overrun <= vsync_rise_s & ((state_r == S_INIT) || (state_r == S_SCAN) ||
                                                 (state_r == S_DONE));
            case (state_r)
                S_INIT: cnt_r <= cnt_r + 10'd1;
                S_IDLE: begin
                    cnt_r <= 10'd0;
                    if (vsync_rise_s) begin
                        x_r         <= 10'd0;
                        y_r         <= 10'd0;
                        row_cnt_r   <= 10'd0;
                        row_found_r <= 1'b0;
                        col_found_r <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (pix_en_s) begin
                        row_cnt_r <= row_cnt_r + {9'd0, pif.per_frame_bit};
                        x_r       <= x_r + 10'd1;
                    end else if (href_fall_s) begin
                        if (row_cnt_r >= ROW_THRESH) begin
                            if (!row_found_r) begin
                                up_tmp_r <= y_r;
                            end
                            down_tmp_r  <= y_r;
                            row_found_r <= 1'b1;
                        end
                        row_cnt_r <= 10'd0;
                        x_r       <= 10'd0;
                        if (y_r < IMG_VDISP) begin
                            y_r <= y_r + 10'd1;
                        end
                    end
                end
                S_SCAN: begin
                    cnt_r <= cnt_r + 10'd1;
                    if ((cnt_r != 10'd0) && (mem_rdata_r >= COL_THRESH)) begin
                        if (!col_found_r) begin
                            left_tmp_r <= cnt_r - 10'd1;
                        end
                        right_tmp_r <= cnt_r - 10'd1;
                        col_found_r <= 1'b1;
                    end
                end
                S_DONE: begin
                    pif.plate_exist_flag    <= exist_s;
                    pif.plate_boarder_up    <= exist_s ? up_tmp_r    : 10'd0;
                    pif.plate_boarder_down  <= exist_s ? down_tmp_r  : 10'd0;
                    pif.plate_boarder_left  <= exist_s ? left_tmp_r  : 10'd0;
                    pif.plate_boarder_right <= exist_s ? right_tmp_r : 10'd0;
                end
                default: cnt_r <= 10'd0;
            endcase
        end
    end
endmodule
